// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: forward-select encodings,
// control bundle bit positions and default widths.
package id_ex_stage_reg_pkg;

    localparam int DW_DEF   = 32;
    localparam int RW_DEF   = 4;
    localparam int OPW_DEF  = 6;
    localparam int CTLW_DEF = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    localparam int CTL_REGWRITE = 0;
    localparam int CTL_MEMRD    = 1;
    localparam int CTL_MEMWR    = 2;

endpackage

// File: rtl/id_ex_stage_reg_operand_fwd_mux.sv
// 4:1 operand forwarding mux: picks the register-file value or one of the
// three in-flight results according to the hazard unit's select.
module operand_fwd_mux
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [1:0]    sel,
    input  logic [DW-1:0] src_rf,
    input  logic [DW-1:0] src_ex,
    input  logic [DW-1:0] src_mem,
    input  logic [DW-1:0] src_wb,
    output logic [DW-1:0] y
);

    always_comb begin
        y = src_rf;
        case (fwd_sel_e'(sel))
            FWD_RF:  y = src_rf;
            FWD_EX:  y = src_ex;
            FWD_MEM: y = src_mem;
            FWD_WB:  y = src_wb;
            default: y = src_rf;
        endcase
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with operand forwarding, stall/flush bubbles and an
// optional bubble counter enabled by ID_EX_BUBBLE_CNT_EN.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int RW   = RW_DEF,
    parameter int OPW  = OPW_DEF,
    parameter int CTLW = CTLW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [DW-1:0]   id_pc,
    input  logic [OPW-1:0]  id_opcode,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic [RW-1:0]   id_rd,
    input  logic [CTLW-1:0] id_ctl,
    input  logic [DW-1:0]   id_imm,
    input  logic [DW-1:0]   rf_a,
    input  logic [DW-1:0]   rf_b,
    input  logic [1:0]      fwd_a_sel,
    input  logic [1:0]      fwd_b_sel,
    input  logic [DW-1:0]   ex_alu_res,
    input  logic [DW-1:0]   mem_res,
    input  logic [DW-1:0]   wb_data,
    input  logic            stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [DW-1:0]   ex_pc,
    output logic [OPW-1:0]  ex_opcode,
    output logic [RW-1:0]   ex_rs,
    output logic [RW-1:0]   ex_rt,
    output logic [RW-1:0]   ex_rd,
    output logic [CTLW-1:0] ex_ctl,
    output logic [DW-1:0]   ex_a,
    output logic [DW-1:0]   ex_b,
    output logic [DW-1:0]   ex_imm,
    output logic            ex_regwrite,
    output logic            ex_memrd,
    output logic [15:0]     bubble_cnt
);

    logic [DW-1:0] a_nxt;
    logic [DW-1:0] b_nxt;
    logic          load_bubble;

    operand_fwd_mux #(.DW(DW)) u_fwd_a (
        .sel     (fwd_a_sel),
        .src_rf  (rf_a),
        .src_ex  (ex_alu_res),
        .src_mem (mem_res),
        .src_wb  (wb_data),
        .y       (a_nxt)
    );

    operand_fwd_mux #(.DW(DW)) u_fwd_b (
        .sel     (fwd_b_sel),
        .src_rf  (rf_b),
        .src_ex  (ex_alu_res),
        .src_mem (mem_res),
        .src_wb  (wb_data),
        .y       (b_nxt)
    );

    // ex_valid qualifies every ex_* field: a slot with ex_valid = 0 is a bubble
    // and must never cause a register or memory write downstream.
    assign load_bubble = flush | stall | ~id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_opcode <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_ctl    <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_imm    <= '0;
        end else if (load_bubble) begin
            ex_valid  <= 1'b0;
            ex_opcode <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_ctl    <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_imm    <= '0;
        end else begin
            ex_valid  <= 1'b1;
            ex_opcode <= id_opcode;
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_rd     <= id_rd;
            ex_ctl    <= id_ctl;
            ex_a      <= a_nxt;
            ex_b      <= b_nxt;
            ex_imm    <= id_imm;
        end
    end

    // PC holds across bubbles so the hazard unit's PC compare sees no change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pc <= '0;
        end else if (!load_bubble) begin
            ex_pc <= id_pc;
        end
    end

    assign ex_regwrite = ex_valid & ex_ctl[CTL_REGWRITE];
    assign ex_memrd    = ex_valid & ex_ctl[CTL_MEMRD];

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q;
    logic        bubble_evt;

    // Only real instructions held back by stall/flush count; idle ID does not.
    assign bubble_evt = id_valid & (stall | flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else if (bubble_evt && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign bubble_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: per-cycle model comparison plus
// hand-computed literal checks for forwarding, bubbles, reset and the counter.
module tb_id_ex_stage_reg;

`ifdef ID_EX_BUBBLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
        logic [7:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        regwrite;
        logic        memrd;
        logic [15:0] cnt;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic        clk, rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_imm, rf_a, rf_b, ex_alu_res, mem_res, wb_data;
    logic [5:0]  id_opcode;
    logic [3:0]  id_rs, id_rt, id_rd;
    logic [7:0]  id_ctl;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall, flush;
    logic        ex_valid, ex_regwrite, ex_memrd;
    logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
    logic [5:0]  ex_opcode;
    logic [3:0]  ex_rs, ex_rt, ex_rd;
    logic [7:0]  ex_ctl;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    exp_t m;
    logic preload_req = 1'b0;
    logic preload_done = 1'b0;

    id_ex_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_ctl(id_ctl), .id_imm(id_imm), .rf_a(rf_a), .rf_b(rf_b),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ex_alu_res(ex_alu_res),
        .mem_res(mem_res), .wb_data(wb_data), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctl(ex_ctl),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_regwrite(ex_regwrite),
        .ex_memrd(ex_memrd), .bubble_cnt(bubble_cnt)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Behavioural model: what the EX slot must hold after each edge.
    always @(posedge clk or negedge rst_n) begin
        logic [31:0] srcs_a[4];
        logic [31:0] srcs_b[4];
        if (!rst_n) begin
            m = '0;
            exp_q.delete();
        end else begin
            srcs_a = '{rf_a, ex_alu_res, mem_res, wb_data};
            srcs_b = '{rf_b, ex_alu_res, mem_res, wb_data};
            if (preload_req && !preload_done) begin
                m.cnt = 16'hFFFE;
                preload_done = 1'b1;
            end
            if (CNT_EN && id_valid && (stall || flush) && m.cnt < 16'hFFFF)
                m.cnt = m.cnt + 16'd1;
            if (id_valid && !stall && !flush) begin
                m.valid  = 1'b1;
                m.pc     = id_pc;
                m.opcode = id_opcode;
                m.rs     = id_rs;
                m.rt     = id_rt;
                m.rd     = id_rd;
                m.ctl    = id_ctl;
                m.a      = srcs_a[fwd_a_sel];
                m.b      = srcs_b[fwd_b_sel];
                m.imm    = id_imm;
            end else begin
                m.valid = 1'b0; m.opcode = '0; m.rs = '0; m.rt = '0; m.rd = '0;
                m.ctl = '0; m.a = '0; m.b = '0; m.imm = '0;
            end
            m.regwrite = m.valid && m.ctl[0];
            m.memrd    = m.valid && m.ctl[1];
            exp_q.push_back(m);
        end
    end

    // Scoreboard compare: every cycle that follows a modelled edge
    always @(negedge clk) begin
        exp_t act;
        logic [EW-1:0] exp_v;
        if (rst_n && exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act = '{ex_valid, ex_pc, ex_opcode, ex_rs, ex_rt, ex_rd, ex_ctl,
                    ex_a, ex_b, ex_imm, ex_regwrite, ex_memrd, bubble_cnt};
            checks++;
            if (act !== exp_t'(exp_v)) begin
                errors++;
                $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [7:0] ctl,
                          input logic [3:0] rd, input logic [1:0] sa, input logic [1:0] sb,
                          input logic st, input logic fl);
        id_valid  = v;
        id_pc     = pc;
        id_ctl    = ctl;
        id_rd     = rd;
        fwd_a_sel = sa;
        fwd_b_sel = sb;
        stall     = st;
        flush     = fl;
        id_opcode = 6'($urandom_range(0, 63));
        id_rs     = 4'($urandom_range(0, 15));
        id_rt     = 4'($urandom_range(0, 15));
        id_imm    = $urandom_range(0, 32'hFFFF);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [7:0] ctl,
                         input logic [3:0] rd, input logic [1:0] sa, input logic [1:0] sb,
                         input logic st, input logic fl);
        set_id(v, pc, ctl, rd, sa, sb, st, fl);
        step();
    endtask

    // Directed stimulus
    initial begin
        logic [31:0] exp_a[4];
        logic [31:0] exp_b[4];
        exp_a = '{32'h11, 32'h22, 32'h33, 32'h44};
        exp_b = '{32'h66, 32'h22, 32'h33, 32'h44};
        rst_n = 1'b0;
        set_id(1'b0, 32'h0, 8'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0);
        rf_a = 32'h11; rf_b = 32'h66;
        ex_alu_res = 32'h22; mem_res = 32'h33; wb_data = 32'h44;
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(ex_valid), 32'h0);
        chk("reset_pc", ex_pc, 32'h0);
        chk("reset_cnt", 32'(bubble_cnt), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + 32'(4 * i), 8'h01, 4'd5, 2'(i), 2'b00, 1'b0, 1'b0);
            chk("fwd_a_sweep", ex_a, exp_a[i]);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h20 + 32'(4 * i), 8'h01, 4'd6, 2'b00, 2'(i), 1'b0, 1'b0);
            chk("fwd_b_sweep", ex_b, exp_b[i]);
        end

        drive(1'b1, 32'h100, 8'h03, 4'd7, 2'b00, 2'b00, 1'b0, 1'b0);
        chk("load_pc", ex_pc, 32'h100);
        chk("load_memrd", 32'(ex_memrd), 32'h1);
        drive(1'b1, 32'h104, 8'h01, 4'd8, 2'b00, 2'b00, 1'b1, 1'b0);
        chk("stall_valid", 32'(ex_valid), 32'h0);
        chk("stall_regwrite", 32'(ex_regwrite), 32'h0);
        chk("stall_pc_hold", ex_pc, 32'h100);
        chk("stall_cnt", 32'(bubble_cnt), CNT_EN ? 32'h1 : 32'h0);
        drive(1'b1, 32'h104, 8'h01, 4'd8, 2'b00, 2'b10, 1'b0, 1'b0);
        chk("after_stall_b", ex_b, 32'h33);
        chk("after_stall_pc", ex_pc, 32'h104);

        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h108, 8'h01, 4'd9, 2'b01, 2'b01, 1'b1, 1'b1);
            chk("flush_stall_valid", 32'(ex_valid), 32'h0);
            chk("flush_stall_rd", 32'(ex_rd), 32'h0);
        end
        chk("flush_stall_cnt", 32'(bubble_cnt), CNT_EN ? 32'h3 : 32'h0);
        chk("flush_stall_pc", ex_pc, 32'h104);

        drive(1'b0, 32'h10C, 8'h02, 4'd9, 2'b00, 2'b00, 1'b0, 1'b0);
        chk("idle_valid", 32'(ex_valid), 32'h0);
        chk("idle_memrd", 32'(ex_memrd), 32'h0);
        chk("idle_cnt", 32'(bubble_cnt), CNT_EN ? 32'h3 : 32'h0);

        drive(1'b1, 32'h110, 8'h01, 4'd0, 2'b11, 2'b11, 1'b0, 1'b0);
        chk("rd0_regwrite", 32'(ex_regwrite), 32'h1);
        chk("rd0_a", ex_a, 32'h44);

`ifdef ID_EX_BUBBLE_CNT_EN
        #3;
        force dut.bubble_cnt_q = 16'hFFFE;
        preload_req = 1'b1;
        #1;
        release dut.bubble_cnt_q;
`endif
        for (int i = 0; i < 3; i++)
            drive(1'b1, 32'h114, 8'h01, 4'd2, 2'b00, 2'b00, 1'b1, 1'b0);
        chk("sat_cnt", 32'(bubble_cnt), CNT_EN ? 32'hFFFF : 32'h0);

        drive(1'b1, 32'h200, 8'h03, 4'd3, 2'b01, 2'b10, 1'b0, 1'b0);
        chk("pre_reset_pc", ex_pc, 32'h200);
        set_id(1'b1, 32'h204, 8'h03, 4'd3, 2'b00, 2'b00, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_valid", 32'(ex_valid), 32'h0);
        chk("midreset_pc", ex_pc, 32'h0);
        chk("midreset_ctl", 32'(ex_ctl), 32'h0);
        chk("midreset_b", ex_b, 32'h0);
        chk("midreset_cnt", 32'(bubble_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h40, 8'h01, 4'd4, 2'b00, 2'b00, 1'b0, 1'b0);
        chk("post_reset_pc", ex_pc, 32'h40);
        chk("post_reset_valid", 32'(ex_valid), 32'h1);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
